// File: rtl/pc_alu_pkg.sv
// Shared types and constants for the PC/ALU execution slice.
package pc_alu_pkg;

  localparam int PC_W = 12;
  localparam int D_W  = 8;

  // Default address at which the top reports completion.
  localparam logic [PC_W-1:0] HALT_ADDR_DFLT = 12'hFFF;

  typedef enum logic [4:0] {
    OP_PASSA = 5'b00000,
    OP_ADDC  = 5'b01101,
    OP_SUBB  = 5'b01110,
    OP_AND   = 5'b01111,
    OP_XOR   = 5'b10000,
    OP_OR    = 5'b10001,
    OP_RSC   = 5'b10010,
    OP_LSC   = 5'b10011,
    OP_NOTA  = 5'b10100,
    OP_PASSB = 5'b10101
  } alu_op_t;

endpackage

// File: rtl/pc_alu_datapath_alu_core.sv
// Combinational 8-bit ALU with carry in/out and compare/zero flags.
module alu_core
  import pc_alu_pkg::*;
(
  input  logic [4:0]     ALUOp,
  input  logic [D_W-1:0] inA,
  input  logic [D_W-1:0] inB,
  input  logic           c_i,
  output logic [D_W-1:0] rslt,
  output logic           c_o,
  output logic           equal,
  output logic           gt,
  output logic           lt,
  output logic           zero
);

  alu_op_t      op;
  logic [D_W:0] sum_ext;
  logic [D_W:0] diff_ext;

  assign op = alu_op_t'(ALUOp);

  // Extended add/subtract; the top bit is carry-out or borrow respectively.
  assign sum_ext  = {1'b0, inA} + {1'b0, inB} + {{D_W{1'b0}}, c_i};
  assign diff_ext = {1'b0, inA} - {1'b0, inB} - {{D_W{1'b0}}, c_i};

  // Opcode decode; unknown opcodes yield zero result and no carry.
  always_comb begin
    rslt = '0;
    c_o  = 1'b0;
    case (op)
      OP_PASSA: rslt = inA;
      OP_ADDC:  {c_o, rslt} = sum_ext;
      OP_SUBB:  {c_o, rslt} = diff_ext;
      OP_AND:   rslt = inA & inB;
      OP_XOR:   rslt = inA ^ inB;
      OP_OR:    rslt = inA | inB;
      OP_RSC: begin
        rslt = {c_i, inA[D_W-1:1]};
        c_o  = inA[0];
      end
      OP_LSC: begin
        rslt = {inA[D_W-2:0], c_i};
        c_o  = inA[D_W-1];
      end
      OP_NOTA:  rslt = ~inA;
      OP_PASSB: rslt = inB;
      default: begin
        rslt = '0;
        c_o  = 1'b0;
      end
    endcase
  end

  // Compare flags look only at the operands; zero looks at the result.
  assign equal = (inA == inB);
  assign gt    = (inA > inB);
  assign lt    = (inA < inB);
  assign zero  = (rslt == '0);

endmodule

// File: rtl/pc_alu_datapath.sv
// Execution slice: program counter with absolute jump, ALU and flag bank.
module pc_alu_datapath
  import pc_alu_pkg::*;
#(
  parameter logic [PC_W-1:0] HALT_ADDR = HALT_ADDR_DFLT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            jump,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] prog_ctr,
  output logic            done,
  input  logic [4:0]      ALUOp,
  input  logic [D_W-1:0]  inA,
  input  logic [D_W-1:0]  inB,
  input  logic            c_i,
  output logic [D_W-1:0]  rslt,
  output logic            c_o,
  output logic            equal,
  output logic            gt,
  output logic            lt,
  output logic            zero,
  output logic            c_q,
  output logic            equalQ,
  output logic            gtQ,
  output logic            ltQ,
  output logic            zeroQ
);

  logic [PC_W-1:0] pc_reg, pc_next;
  logic            done_reg, done_next;
  logic [4:0]      flags_reg;

  alu_core u_alu (
    .ALUOp (ALUOp),
    .inA   (inA),
    .inB   (inB),
    .c_i   (c_i),
    .rslt  (rslt),
    .c_o   (c_o),
    .equal (equal),
    .gt    (gt),
    .lt    (lt),
    .zero  (zero)
  );

  // Next PC: hold-at-zero while idle, then jump, else increment (wraps naturally).
  // done is computed from the next PC so it lines up with prog_ctr.
  always_comb begin
    pc_next   = pc_reg + 1'b1;
    done_next = 1'b0;
    if (start) begin
      pc_next = '0;
    end else if (jump) begin
      pc_next = target;
    end
    done_next = !start && (pc_next == HALT_ADDR);
  end

  // Program counter and completion register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg   <= '0;
      done_reg <= 1'b0;
    end else begin
      pc_reg   <= pc_next;
      done_reg <= done_next;
    end
  end

  // Flag bank captures ALU carry and flags while running, freezes while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_reg <= '0;
    end else if (!start) begin
      flags_reg <= {c_o, equal, gt, lt, zero};
    end
  end

  assign prog_ctr = pc_reg;
  assign done     = done_reg;
  assign {c_q, equalQ, gtQ, ltQ, zeroQ} = flags_reg;

endmodule

// File: tb/tb_pc_alu_datapath.sv
// Directed self-checking bench for pc_alu_datapath.
module tb_pc_alu_datapath;

  logic        clk;
  logic        reset;
  logic        start;
  logic        jump;
  logic [11:0] target;
  logic [11:0] prog_ctr;
  logic        done;
  logic [4:0]  ALUOp;
  logic [7:0]  inA, inB;
  logic        c_i;
  logic [7:0]  rslt;
  logic        c_o, equal, gt, lt, zero;
  logic        c_q, equalQ, gtQ, ltQ, zeroQ;

  int checks   = 0;
  int failures = 0;

  pc_alu_datapath dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .jump     (jump),
    .target   (target),
    .prog_ctr (prog_ctr),
    .done     (done),
    .ALUOp    (ALUOp),
    .inA      (inA),
    .inB      (inB),
    .c_i      (c_i),
    .rslt     (rslt),
    .c_o      (c_o),
    .equal    (equal),
    .gt       (gt),
    .lt       (lt),
    .zero     (zero),
    .c_q      (c_q),
    .equalQ   (equalQ),
    .gtQ      (gtQ),
    .ltQ      (ltQ),
    .zeroQ    (zeroQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] e_rslt;
    logic       e_co;
    logic       e_eq;
    logic       e_gt;
    logic       e_lt;
    logic       e_zero;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic chk_q(input string tag, input logic co, input logic eq,
                       input logic g, input logic l, input logic z);
    chk({tag, " c_q"},    int'(c_q),    int'(co));
    chk({tag, " equalQ"}, int'(equalQ), int'(eq));
    chk({tag, " gtQ"},    int'(gtQ),    int'(g));
    chk({tag, " ltQ"},    int'(ltQ),    int'(l));
    chk({tag, " zeroQ"},  int'(zeroQ),  int'(z));
  endtask

  initial begin
    //           op        a      b      ci    rslt   co    eq    gt    lt    z
    vecs[0]  = '{5'b01101, 8'h01, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{5'b01101, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{5'b01101, 8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{5'b01110, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{5'b01110, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{5'b01110, 8'h05, 8'h05, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{5'b01110, 8'h05, 8'h04, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{5'b01111, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{5'b10000, 8'h71, 8'h24, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{5'b10001, 8'h0F, 8'h30, 1'b1, 8'h3F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{5'b10010, 8'h71, 8'h00, 1'b1, 8'hB8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{5'b10011, 8'h80, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{5'b10011, 8'h55, 8'h55, 1'b1, 8'hAB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{5'b10100, 8'h3C, 8'h3C, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{5'b10101, 8'h12, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[15] = '{5'b00000, 8'hA5, 8'h5A, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{5'b11111, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[17] = '{5'b00001, 8'h02, 8'h09, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset with ALU inputs that would set flags if the bank were not frozen.
    reset = 1'b1; start = 1'b1; jump = 1'b0; target = '0;
    ALUOp = 5'b01101; inA = 8'hFF; inB = 8'h01; c_i = 1'b0;
    #1;
    chk("reset pc", int'(prog_ctr), 0);
    chk("reset done", int'(done), 0);
    chk_q("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Idle: PC held at zero, flags frozen.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("idle%0d pc", i), int'(prog_ctr), 0);
      chk($sformatf("idle%0d done", i), int'(done), 0);
    end
    chk_q("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Run: count 1,2,3.
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("count%0d pc", i), int'(prog_ctr), i);
    end

    // Absolute jump, then increment.
    @(negedge clk);
    jump = 1'b1; target = 12'h257;
    @(posedge clk); #1;
    chk("jump pc", int'(prog_ctr), 'h257);
    jump = 1'b0;
    @(posedge clk); #1;
    chk("post-jump pc", int'(prog_ctr), 'h258);
    chk("post-jump done", int'(done), 0);

    // Halt address asserts done, then wraps to zero and done drops.
    @(negedge clk);
    jump = 1'b1; target = 12'hFFF;
    @(posedge clk); #1;
    chk("halt pc", int'(prog_ctr), 'hFFF);
    chk("halt done", int'(done), 1);
    jump = 1'b0;
    @(posedge clk); #1;
    chk("wrap pc", int'(prog_ctr), 0);
    chk("wrap done", int'(done), 0);

    // Reaching the halt address by incrementing.
    @(negedge clk);
    jump = 1'b1; target = 12'hFFE;
    @(posedge clk); #1;
    jump = 1'b0;
    chk("pre-halt done", int'(done), 0);
    @(posedge clk); #1;
    chk("inc halt pc", int'(prog_ctr), 'hFFF);
    chk("inc halt done", int'(done), 1);

    // start beats jump.
    @(negedge clk);
    start = 1'b1; jump = 1'b1; target = 12'h123;
    @(posedge clk); #1;
    chk("start+jump pc", int'(prog_ctr), 0);
    chk("start+jump done", int'(done), 0);
    start = 1'b0; jump = 1'b0;

    // ALU vector table: combinational check, then registered flags after the edge.
    foreach (vecs[i]) begin
      @(negedge clk);
      ALUOp = vecs[i].op; inA = vecs[i].a; inB = vecs[i].b; c_i = vecs[i].ci;
      #1;
      chk($sformatf("v%0d rslt", i),  int'(rslt),  int'(vecs[i].e_rslt));
      chk($sformatf("v%0d c_o", i),   int'(c_o),   int'(vecs[i].e_co));
      chk($sformatf("v%0d equal", i), int'(equal), int'(vecs[i].e_eq));
      chk($sformatf("v%0d gt", i),    int'(gt),    int'(vecs[i].e_gt));
      chk($sformatf("v%0d lt", i),    int'(lt),    int'(vecs[i].e_lt));
      chk($sformatf("v%0d zero", i),  int'(zero),  int'(vecs[i].e_zero));
      @(posedge clk); #1;
      chk_q($sformatf("v%0d", i), vecs[i].e_co, vecs[i].e_eq, vecs[i].e_gt,
            vecs[i].e_lt, vecs[i].e_zero);
    end

    // Asynchronous reset mid-cycle while running at PC 0x010 with flags set.
    @(negedge clk);
    jump = 1'b1; target = 12'h010;
    ALUOp = 5'b01101; inA = 8'hFF; inB = 8'h01; c_i = 1'b0;
    @(posedge clk); #1;
    jump = 1'b0;
    chk("pre-reset pc", int'(prog_ctr), 'h010);
    chk_q("pre-reset", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    chk("async reset pc", int'(prog_ctr), 0);
    chk("async reset done", int'(done), 0);
    chk_q("async reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("after reset pc", int'(prog_ctr), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
